quantizer: RTL

QUANTIZER -- requirements
Module: quantizer

---
 rtl/quantizer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/quantizer.sv
// JPEG luminance quantizer: one signed DCT coefficient in, one rounded, saturated quotient out.
// Each coefficient is divided by its position's entry in the standard luminance table
// using a serial restoring divider (one quotient bit per cycle). Only one coefficient is
// in flight at a time.
//
// Ports
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   dct_veri_i                signed coefficient (COEF_W)
//   dct_veri_row_i/_col_i     position of the coefficient in the 8x8 block
//   dct_veri_gecerli_i        upstream valid
//   dct_blok_son_i            last coefficient of the block
//   dct_veri_hazir_o          upstream ready (high only while idle)
//   zig_veri_o                signed quantized value (OUT_W)
//   zig_veri_row_o/_col_o     position carried with the value
//   zig_veri_gecerli_o        downstream valid
//   zig_blok_son_o            last of block, qualified by zig_veri_gecerli_o
//   zig_veri_hazir_i          downstream ready
module quantizer #(
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned OUT_W     = 12,
  parameter int unsigned BLOCK_BIT = 3
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic signed [COEF_W-1:0]    dct_veri_i,
  input  logic        [BLOCK_BIT-1:0] dct_veri_row_i,
  input  logic        [BLOCK_BIT-1:0] dct_veri_col_i,
  input  logic                        dct_veri_gecerli_i,
  input  logic                        dct_blok_son_i,
  output logic                        dct_veri_hazir_o,
  output logic signed [OUT_W-1:0]     zig_veri_o,
  output logic        [BLOCK_BIT-1:0] zig_veri_row_o,
  output logic        [BLOCK_BIT-1:0] zig_veri_col_o,
  output logic                        zig_veri_gecerli_o,
  output logic                        zig_blok_son_o,
  input  logic                        zig_veri_hazir_i
);

  // Dividend is |x| + floor(T/2); one extra bit so |-2^(COEF_W-1)| fits.
  localparam int unsigned DivW = COEF_W + 1;
  localparam int unsigned CntW = $clog2(DivW + 1);
  localparam int unsigned IdxW = 2 * BLOCK_BIT;
  localparam logic [OUT_W-1:0] SatMag = {1'b0, {(OUT_W-1){1'b1}}};

  // Standard JPEG luminance quantization table, row-major.
  localparam logic [7:0] QTable [64] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  typedef enum logic [1:0] {StIdle, StDiv, StOut} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DivW-1:0]       quo_q, quo_d;   // dividend shifting out, quotient shifting in
  logic [7:0]            rem_q, rem_d;
  logic [7:0]            div_q, div_d;
  logic                  neg_q, neg_d;
  logic [BLOCK_BIT-1:0]  row_q, row_d;
  logic [BLOCK_BIT-1:0]  col_q, col_d;
  logic                  son_q, son_d;
  logic                  hazir_q, hazir_d;
  logic [OUT_W-1:0]      out_q, out_d;
  logic [BLOCK_BIT-1:0]  out_row_q, out_row_d;
  logic [BLOCK_BIT-1:0]  out_col_q, out_col_d;
  logic                  out_vld_q, out_vld_d;
  logic                  out_son_q, out_son_d;

  logic [IdxW-1:0]       idx;
  logic [7:0]            t_sel;
  logic                  x_sign;
  logic [DivW-1:0]       x_ext;
  logic [DivW-1:0]       abs_x;
  logic [DivW-1:0]       d_in;
  logic [8:0]            rem_sh;
  logic                  ge;
  logic [OUT_W-1:0]      mag;
  logic [OUT_W-1:0]      res;

  always_comb begin
    idx    = (IdxW'(dct_veri_row_i) * IdxW'(8)) + IdxW'(dct_veri_col_i);
    t_sel  = QTable[idx];
    x_sign = dct_veri_i[COEF_W-1];
    x_ext  = {x_sign, dct_veri_i};
    abs_x  = (x_ext ^ {DivW{x_sign}}) + DivW'(x_sign);
    d_in   = abs_x + DivW'(t_sel >> 1);

    rem_sh = {rem_q, quo_q[DivW-1]};
    ge     = (rem_sh >= {1'b0, div_q});

    mag    = (quo_q > DivW'(SatMag)) ? SatMag : quo_q[OUT_W-1:0];
    // Negating zero yields zero, so no negative zero is produced.
    res    = (mag ^ {OUT_W{neg_q}}) + OUT_W'(neg_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    neg_d     = neg_q;
    row_d     = row_q;
    col_d     = col_q;
    son_d     = son_q;
    hazir_d   = hazir_q;
    out_d     = out_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    out_vld_d = out_vld_q;
    out_son_d = out_son_q;

    unique case (state_q)
      StIdle: begin
        hazir_d = 1'b1;
        if (dct_veri_gecerli_i && hazir_q) begin
          state_d = StDiv;
          hazir_d = 1'b0;
          cnt_d   = '0;
          quo_d   = d_in;
          rem_d   = '0;
          div_d   = t_sel;
          neg_d   = x_sign;
          row_d   = dct_veri_row_i;
          col_d   = dct_veri_col_i;
          son_d   = dct_blok_son_i;
        end
      end
      StDiv: begin
        if (cnt_q == CntW'(DivW)) begin
          state_d   = StOut;
          out_vld_d = 1'b1;
          out_d     = res;
          out_row_d = row_q;
          out_col_d = col_q;
          out_son_d = son_q;
        end else begin
          quo_d = {quo_q[DivW-2:0], ge};
          rem_d = ge ? 8'(rem_sh - {1'b0, div_q}) : rem_sh[7:0];
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StOut: begin
        if (zig_veri_hazir_i) begin
          state_d   = StIdle;
          out_vld_d = 1'b0;
          out_son_d = 1'b0;
          hazir_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      neg_q     <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      son_q     <= 1'b0;
      hazir_q   <= 1'b0;
      out_q     <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      out_vld_q <= 1'b0;
      out_son_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      row_q     <= row_d;
      col_q     <= col_d;
      son_q     <= son_d;
      hazir_q   <= hazir_d;
      out_q     <= out_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      out_vld_q <= out_vld_d;
      out_son_q <= out_son_d;
    end
  end

  assign dct_veri_hazir_o   = hazir_q;
  assign zig_veri_o         = out_q;
  assign zig_veri_row_o     = out_row_q;
  assign zig_veri_col_o     = out_col_q;
  assign zig_veri_gecerli_o = out_vld_q;
  assign zig_blok_son_o     = out_son_q;

endmodule
